// File: rtl/mux4_rr_arbiter_if.sv
// Handshake bundle between four requesters and the shared 4:1 mux arbiter.
// The master side drives requests and data bits; the slave side is the arbiter.
interface mux4_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] x;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       y;
    logic       busy;

    modport master (output req, x, input gnt, s, y, busy);
    modport slave  (input req, x, output gnt, s, y, busy);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a 4:1 single-bit mux, with a hold-time limit on each owner.
// Optional macro ARB_PARK_EN: keep the last owner's select while idle instead of forcing 00.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mux4_rr_arbiter_if.slave     bus
);
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic [1:0]    rr_ptr;
    logic [3:0]    gnt_r;
    logic [1:0]    s_r;
    logic          busy_r;

    logic [3:0]    others;
    logic          release_own;
    logic [2:0]    pick;

    // Returns {found, index}; scanning downwards lets the smallest offset from start win.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // While owning, s_r is the owner index; masking it gives the handover candidates.
    always_comb begin
        others      = bus.req & ~(4'b0001 << s_r);
        release_own = !bus.req[s_r] || (hold_cnt == HOLD_LAST && others != 4'b0000);
        pick        = (state == IDLE) ? rr_pick(bus.req, rr_ptr)
                                      : rr_pick(others, s_r + 2'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt_r    <= 4'b0000;
            s_r      <= 2'b00;
            busy_r   <= 1'b0;
            hold_cnt <= '0;
            rr_ptr   <= 2'b00;
        end else if (state == IDLE || release_own) begin
            if (pick[2]) begin
                state    <= OWN;
                gnt_r    <= 4'b0001 << pick[1:0];
                s_r      <= pick[1:0];
                busy_r   <= 1'b1;
                hold_cnt <= '0;
                rr_ptr   <= pick[1:0] + 2'd1;
            end else begin
                state    <= IDLE;
                gnt_r    <= 4'b0000;
                busy_r   <= 1'b0;
                hold_cnt <= '0;
`ifdef ARB_PARK_EN
                s_r      <= s_r;
`else
                s_r      <= 2'b00;
`endif
            end
        end else if (hold_cnt != HOLD_LAST) begin
            // Saturating count: a lone owner is never preempted.
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign bus.gnt  = gnt_r;
    assign bus.s    = s_r;
    assign bus.busy = busy_r;
    assign bus.y    = bus.x[s_r];
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural ownership model.
module tb_mux4_rr_arbiter;
    localparam int MAX_HOLD = 8;
`ifdef ARB_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    logic clk;
    logic rst;
    mux4_rr_arbiter_if bus();

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Behavioural model: who owns the mux, for how long, and whose turn is next.
    int m_owner;
    int m_hold;
    int m_ptr;
    int m_s;

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++)
            if (r[(start + i) % 4]) return (start + i) % 4;
        return -1;
    endfunction

    task automatic give_to(input int p);
        m_owner = p;
        m_hold  = 0;
        m_ptr   = (p + 1) % 4;
        m_s     = p;
    endtask

    task automatic model_step(input logic [3:0] r);
        int p;
        logic [3:0] rest;
        if (m_owner < 0) begin
            p = first_from(r, m_ptr);
            if (p >= 0) give_to(p);
        end else begin
            rest = r;
            rest[m_owner] = 1'b0;
            if (!r[m_owner] || (m_hold == MAX_HOLD - 1 && rest != 4'b0000)) begin
                p = first_from(rest, (m_owner + 1) % 4);
                if (p >= 0) give_to(p);
                else begin
                    m_owner = -1;
                    if (!PARK) m_s = 0;
                end
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold++;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_hold  = 0;
            m_ptr   = 0;
            m_s     = 0;
        end else begin
            model_step(bus.req);
        end
    end

    // Per-cycle comparison against the model, well after the edge.
    logic [3:0] exp_gnt;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
                chk("cyc_gnt",    bus.gnt, exp_gnt);
                chk("cyc_s",      bus.s, m_s[1:0]);
                chk("cyc_busy",   bus.busy, (m_owner >= 0));
                chk("cyc_y",      bus.y, bus.x[m_s]);
                chk("cyc_onehot", $countones(bus.gnt) <= 1, 1);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int cnt;

    initial begin
        rst     = 1'b1;
        bus.req = 4'b0000;
        bus.x   = 4'b0001;
        #12;
        chk("rst_gnt",  bus.gnt, 4'b0000);
        chk("rst_s",    bus.s, 2'b00);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_y_x0", bus.y, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Single requester, then drop.
        bus.req = 4'b0100;
        bus.x   = 4'b1010;
        @(negedge clk);
        chk("t1_gnt",  bus.gnt, 4'b0100);
        chk("t1_s",    bus.s, 2'b10);
        chk("t1_busy", bus.busy, 1'b1);
        chk("t1_y",    bus.y, 1'b0);
        bus.req = 4'b0000;
        @(negedge clk);
        chk("t1_idle_gnt",  bus.gnt, 4'b0000);
        chk("t1_idle_busy", bus.busy, 1'b0);
        chk("t1_idle_s",    bus.s, PARK ? 2'b10 : 2'b00);
        chk("t1_idle_y",    bus.y, 1'b0);

        // Full rotation with zero-bubble handovers.
        do_reset();
        bus.req = 4'hF;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("t2_gnt",  bus.gnt, 4'b0001 << (i % 4));
            chk("t2_busy", bus.busy, 1'b1);
            bus.req = 4'hF;
            @(negedge clk);
            bus.req = 4'hF & ~(4'b0001 << (i % 4));
            @(negedge clk);
        end
        bus.req = 4'b0000;

        // Hold limit preemption: owner 0 keeps the mux for exactly MAX_HOLD cycles.
        do_reset();
        bus.req = 4'b0001;
        @(negedge clk);
        cnt = 0;
        while (bus.gnt == 4'b0001 && cnt < 20) begin
            cnt++;
            if (cnt == 3) bus.req = 4'b0101;
            @(negedge clk);
        end
        chk("t3_hold_cycles", cnt, MAX_HOLD);
        chk("t3_gnt_pre",     bus.gnt, 4'b0100);
        @(negedge clk);
        @(negedge clk);
        bus.req = 4'b0001;
        @(negedge clk);
        chk("t3_regrant0", bus.gnt, 4'b0001);

        // Lone owner is never preempted.
        do_reset();
        bus.req = 4'b0010;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            chk("t4_gnt",  bus.gnt, 4'b0010);
            chk("t4_busy", bus.busy, 1'b1);
            @(negedge clk);
        end

        // Owner drop coincides with a new request.
        do_reset();
        bus.req = 4'b1000;
        @(negedge clk);
        chk("t5_gnt3", bus.gnt, 4'b1000);
        bus.req = 4'b0001;
        @(negedge clk);
        chk("t5_gnt0", bus.gnt, 4'b0001);
        chk("t5_s",    bus.s, 2'b00);
        chk("t5_busy", bus.busy, 1'b1);

        // Asynchronous reset mid-ownership.
        do_reset();
        bus.req = 4'b0100;
        @(negedge clk);
        chk("t6_gnt2", bus.gnt, 4'b0100);
        #2 rst = 1'b1;
        #0.5;
        chk("t6_rst_gnt",  bus.gnt, 4'b0000);
        chk("t6_rst_s",    bus.s, 2'b00);
        chk("t6_rst_busy", bus.busy, 1'b0);
        #0.5 rst = 1'b0;
        bus.req = 4'hF;
        @(negedge clk);
        chk("t6_first0", bus.gnt, 4'b0001);

        // Randomized traffic with sticky requests and occasional async resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if (bus.req[b]) begin
                    if ($urandom_range(0, 5) == 0) bus.req[b] = 1'b0;
                end else begin
                    if ($urandom_range(0, 3) == 0) bus.req[b] = 1'b1;
                end
            end
            bus.x = 4'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
